unsigned_mul_8x8_ha_reduce: RTL and testbench
=============================================

UNSIGNED_MUL_8X8_HA_REDUCE -- requirements
Module: unsigned_mul_8x8_ha_reduce

Interface
REQ-001 SHALL have parameter OUT_W, default 16, meaning the product output width; only 16 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the sole clock, rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the half-adder-array bundle is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the bundle this cycle.
REQ-006 SHALL have ports ha_array_k_b, input, 7 bits each (k = 0..3): carry rows from the upstream half-adder array stage.
REQ-007 SHALL have ports ha_array_k_t, input, 9 bits each (k = 0..3): sum rows from the upstream half-adder array stage.
REQ-008 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-010 SHALL have port product, output, OUT_W bits: the reduced product.
REQ-011 SHALL have port ovf, output, 1 bit: the 17-bit sum exceeded 16 bits.
REQ-012 SHALL have port result_cnt, output, 16 bits: count of products consumed since reset.

Function
REQ-013 Weighting SHALL be: array k value A_k = t_k + (b_k << 2), with bit b_k[i] at weight i+2 and t_k[i] at weight i.
REQ-014 The full sum SHALL be P = A_0 + (A_1 << 2) + (A_2 << 4) + (A_3 << 6), computed at 17 bits with no truncation before stage 2.
REQ-015 Stage 1 SHALL register S01 = A_0 + (A_1 << 2) and S23 = A_2 + (A_3 << 2), 13 bits each, plus a valid bit v1.
REQ-016 Stage 2 SHALL register P = S01 + (S23 << 4), 17 bits, plus a valid bit v2.
REQ-017 product SHALL equal P[15:0], and ovf SHALL equal P[16].
REQ-018 out_valid SHALL equal v2.
REQ-019 Latency SHALL be exactly 2 cycles from an accepted input (in_valid & in_ready) to out_valid, provided there is no backpressure.
REQ-020 Stage 2 SHALL load when !v2 | out_ready.
REQ-021 Stage 1 SHALL load when !v1 | (stage 2 loads).
REQ-022 in_ready SHALL equal the stage-1 load condition, be combinational, and have no dependence on in_valid.
REQ-023 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-024 With out_ready = 0 and both stages full, in_ready SHALL be 0, and the held data SHALL stay unchanged.
REQ-025 When a stage loads with no valid upstream data, its valid bit SHALL clear; its data register MAY hold stale values.
REQ-026 While out_valid = 1 and out_ready = 0, product and ovf SHALL be held stable.
REQ-027 result_cnt SHALL increment on each out_valid & out_ready and wrap from 0xFFFF to 0x0000.
REQ-028 A simultaneous accept at the input and consume at the output SHALL occur in the same cycle with no bubble.

Reset
REQ-029 On rst_n low, the block SHALL immediately and asynchronously clear v1, v2, S01, S23, P and result_cnt.
REQ-030 During reset, out_valid = 0, product = 0, ovf = 0 and result_cnt = 0; in_ready SHALL then read 1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight bundles, and no output SHALL appear for them after deassertion.
REQ-032 Reset deassertion SHALL be synchronised externally; the block SHALL first accept input on the first clk edge after deassertion.

Structure
REQ-033 A shared package SHALL hold the constants HA_B_W = 7, HA_T_W = 9, HA_N = 4, ROW_SHIFT = 2 and P_W = 17.
REQ-034 The shared package SHALL also hold a struct type for one {b, t} array pair.
REQ-035 One sub-module, ha_row_value, SHALL be used, instantiated four times, combinationally computing A_k = t + (b << 2) at 11 bits.
REQ-036 No multiplication operator SHALL be used; only shifts and adds.

Verification
REQ-037 All arrays zero, in_valid one cycle -> two cycles later out_valid = 1, product = 0x0000, ovf = 0.
REQ-038 Only ha_array_3_t = 9'h1FF -> product = 0x7FC0, ovf = 0.
REQ-039 All b inputs = 7'h7F and all t inputs = 9'h1FF -> P = 86615, product = 0x5257, ovf = 1.
REQ-040 Upstream arrays generated from x = 8'd13, y = 8'd11 -> product = 143, matching a golden model of the upstream approximate arrays.
REQ-041 Backpressure: 3 back-to-back bundles with out_ready held 0 -> in_ready = 0 after 2 accepts; releasing out_ready -> 3 results in order, no loss or duplication.
REQ-042 Reset mid-stream with v1 = v2 = 1 -> out_valid = 0 immediately, result_cnt = 0, and no stale result after release.

Source files
------------

// File: rtl/unsigned_mul_8x8_ha_reduce_pkg.sv
// -----------------------------------------------------------------------------
// unsigned_mul_8x8_ha_reduce_pkg
// Shared constants and types for the 8x8 half-adder-array reduction block.
//   HA_B_W / HA_T_W : widths of one carry row (b) and one sum row (t)
//   HA_N            : number of upstream half-adder arrays
//   ROW_SHIFT       : weight step between b and t, and between adjacent arrays
//   GROUP_SHIFT     : weight step between the two stage-1 partial sums
//   A_W / S_W / P_W : widths of an array value, a stage-1 sum, the full sum
// -----------------------------------------------------------------------------
package unsigned_mul_8x8_ha_reduce_pkg;

   localparam int HA_B_W      = 7;
   localparam int HA_T_W      = 9;
   localparam int HA_N        = 4;
   localparam int ROW_SHIFT   = 2;
   localparam int GROUP_SHIFT = ROW_SHIFT + ROW_SHIFT;
   localparam int A_W         = 11;
   localparam int S_W         = 13;
   localparam int P_W         = 17;

   // One upstream half-adder array: carry row b (weight +2) and sum row t.
   typedef struct packed {
      logic [HA_B_W-1:0] b;
      logic [HA_T_W-1:0] t;
   } ha_pair_t;

endpackage

// File: rtl/unsigned_mul_8x8_ha_reduce_ha_row_value.sv
// -----------------------------------------------------------------------------
// ha_row_value
// Combinational value of one half-adder array: A = t + (b << ROW_SHIFT).
//   pair_i : {b, t} rows of one array
//   a_o    : array value, A_W bits (cannot overflow: max 511 + 508)
// -----------------------------------------------------------------------------
module ha_row_value
   import unsigned_mul_8x8_ha_reduce_pkg::*;
(
   input  ha_pair_t         pair_i,
   output logic [A_W-1:0]   a_o
);

   assign a_o = A_W'(pair_i.t) + (A_W'(pair_i.b) << ROW_SHIFT);

endmodule

// File: rtl/unsigned_mul_8x8_ha_reduce.sv
// -----------------------------------------------------------------------------
// unsigned_mul_8x8_ha_reduce
// Two-stage valid/ready pipeline that reduces four half-adder arrays of an
// 8x8 unsigned multiplier into the final product using only shifts and adds.
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid / in_ready      : input handshake (in_ready independent of in_valid)
//   ha_array_k_b / _t        : carry (7b) and sum (9b) rows of array k = 0..3
//   out_valid / out_ready    : output handshake
//   product                  : P[15:0] of the 17-bit reduced sum
//   ovf                      : P[16]
//   result_cnt               : products consumed since reset, wraps at 16 bits
// Stage 1 holds S01 = A0 + (A1<<2) and S23 = A2 + (A3<<2); stage 2 holds
// P = S01 + (S23<<4).
// -----------------------------------------------------------------------------
module unsigned_mul_8x8_ha_reduce
   import unsigned_mul_8x8_ha_reduce_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [HA_B_W-1:0]   ha_array_0_b,
   input  logic [HA_B_W-1:0]   ha_array_1_b,
   input  logic [HA_B_W-1:0]   ha_array_2_b,
   input  logic [HA_B_W-1:0]   ha_array_3_b,
   input  logic [HA_T_W-1:0]   ha_array_0_t,
   input  logic [HA_T_W-1:0]   ha_array_1_t,
   input  logic [HA_T_W-1:0]   ha_array_2_t,
   input  logic [HA_T_W-1:0]   ha_array_3_t,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_W-1:0]    product,
   output logic                ovf,
   output logic [15:0]         result_cnt
);

   ha_pair_t         pairs [HA_N];
   logic [A_W-1:0]   a_val [HA_N];

   logic             v1_q, v1_d, v2_q, v2_d;
   logic [S_W-1:0]   s01_q, s01_d, s23_q, s23_d;
   logic [P_W-1:0]   p_q, p_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             load1, load2;

   assign pairs[0] = '{b: ha_array_0_b, t: ha_array_0_t};
   assign pairs[1] = '{b: ha_array_1_b, t: ha_array_1_t};
   assign pairs[2] = '{b: ha_array_2_b, t: ha_array_2_t};
   assign pairs[3] = '{b: ha_array_3_b, t: ha_array_3_t};

   for (genvar k = 0; k < HA_N; k++) begin : g_row
      ha_row_value u_row (
         .pair_i (pairs[k]),
         .a_o    (a_val[k])
      );
   end

   // Each stage advances when it is empty or its consumer is taking its data.
   assign load2    = !v2_q || out_ready;
   assign load1    = !v1_q || load2;
   assign in_ready = load1;

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path
      // through this block leaves a variable unassigned (which would infer a latch).
      v1_d  = v1_q;
      s01_d = s01_q;
      s23_d = s23_q;
      v2_d  = v2_q;
      p_d   = p_q;
      cnt_d = cnt_q;

      if (load1) begin
         v1_d = in_valid;
         // Data only captured when valid; a bubble leaves stale data behind v1=0.
         if (in_valid) begin
            s01_d = S_W'(a_val[0]) + (S_W'(a_val[1]) << ROW_SHIFT);
            s23_d = S_W'(a_val[2]) + (S_W'(a_val[3]) << ROW_SHIFT);
         end
      end

      if (load2) begin
         v2_d = v1_q;
         if (v1_q) begin
            p_d = P_W'(s01_q) + (P_W'(s23_q) << GROUP_SHIFT);
         end
      end

      if (v2_q && out_ready) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; the datapath is cleared too so outputs read 0 in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         s01_q <= '0;
         s23_q <= '0;
         v2_q  <= 1'b0;
         p_q   <= '0;
         cnt_q <= '0;
      end else begin
         v1_q  <= v1_d;
         s01_q <= s01_d;
         s23_q <= s23_d;
         v2_q  <= v2_d;
         p_q   <= p_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_valid  = v2_q;
   assign product    = p_q[OUT_W-1:0];
   assign ovf        = p_q[P_W-1];
   assign result_cnt = cnt_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_reduce.sv
// -----------------------------------------------------------------------------
// tb_unsigned_mul_8x8_ha_reduce
// Directed-vector bench for the half-adder-array reduction pipeline. Inputs are
// driven 1 ns after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_unsigned_mul_8x8_ha_reduce;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        ovf;
   logic [15:0] result_cnt;
   logic [6:0]  b [4];
   logic [8:0]  t [4];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   unsigned_mul_8x8_ha_reduce #(.OUT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ha_array_0_b (b[0]),
      .ha_array_1_b (b[1]),
      .ha_array_2_b (b[2]),
      .ha_array_3_b (b[3]),
      .ha_array_0_t (t[0]),
      .ha_array_1_t (t[1]),
      .ha_array_2_t (t[2]),
      .ha_array_3_t (t[3]),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .ovf          (ovf),
      .result_cnt   (result_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_arrays();
      for (int k = 0; k < 4; k++) begin
         b[k] = '0;
         t[k] = '0;
      end
   endtask

   // Upstream arrays for x*y: array k covers y bit pair k. The x term goes
   // into t; the 2x term is split into its low two bits (t) and the rest (b).
   task automatic build_from_xy(input logic [7:0] x, input logic [7:0] y);
      logic [8:0] two_x;
      for (int k = 0; k < 4; k++) begin
         two_x = y[2*k+1] ? {x, 1'b0} : 9'd0;
         t[k]  = (y[2*k] ? {1'b0, x} : 9'd0) + {7'd0, two_x[1:0]};
         b[k]  = two_x[8:2];
      end
   endtask

   // Arrays must already be set; out_ready must be 1. Consumes the result.
   task automatic run_vec(input string tag, input logic [16:0] exp_p);
      int lat;
      in_valid = 1'b1;
      check({tag, "_rdy"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, 2);
      check({tag, "_prod"}, product, exp_p[15:0]);
      check({tag, "_ovf"}, ovf, exp_p[16]);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      clear_arrays();

      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 0);
      check("rst_ovf", ovf, 0);
      check("rst_cnt", result_cnt, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single bundles with hand-computed sums.
      clear_arrays();
      run_vec("zero", 17'h00000);
      clear_arrays();
      t[3] = 9'h1FF;
      run_vec("t3max", 17'h07FC0);
      for (int k = 0; k < 4; k++) begin
         b[k] = 7'h7F;
         t[k] = 9'h1FF;
      end
      run_vec("allmax", 17'd86615);
      build_from_xy(8'd13, 8'd11);
      run_vec("x13y11", 17'd143);
      check("cnt_after4", result_cnt, 4);

      // Back-to-back stream: one result per cycle.
      for (int i = 0; i < 5; i++) begin
         clear_arrays();
         if (i < 4) begin
            t[0]     = 9'(i + 1);
            in_valid = 1'b1;
            check("tp_rdy", in_ready, 1);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (i >= 1) begin
            check("tp_valid", out_valid, 1);
            check("tp_prod", product, 32'(i));
         end
      end
      tick();
      check("tp_empty", out_valid, 0);
      check("tp_cnt", result_cnt, 8);

      // Backpressure: three bundles (P = 1, 4, 64) with out_ready low.
      out_ready = 1'b0;
      clear_arrays();
      t[0]     = 9'd1;
      in_valid = 1'b1;
      check("bp_rdy0", in_ready, 1);
      tick();
      clear_arrays();
      t[1] = 9'd1;
      check("bp_rdy1", in_ready, 1);
      tick();
      clear_arrays();
      b[2] = 7'd1;
      check("bp_full", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_hold0", product, 1);
      tick();
      tick();
      check("bp_hold1", product, 1);
      check("bp_full2", in_ready, 0);
      out_ready = 1'b1;
      #1;
      check("bp_rel_rdy", in_ready, 1);
      check("bp_r0", product, 1);
      tick();
      in_valid = 1'b0;
      check("bp_r1_valid", out_valid, 1);
      check("bp_r1", product, 4);
      tick();
      check("bp_r2_valid", out_valid, 1);
      check("bp_r2", product, 64);
      tick();
      check("bp_drained", out_valid, 0);
      check("bp_cnt", result_cnt, 11);

      // Reset with both stages full.
      out_ready = 1'b0;
      clear_arrays();
      t[0]     = 9'd5;
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      check("rs_full", in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rs_out_valid", out_valid, 0);
      check("rs_cnt", result_cnt, 0);
      check("rs_product", product, 0);
      check("rs_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      seen      = 1'b0;
      repeat (6) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("rs_no_stale", seen, 0);
      clear_arrays();
      t[1] = 9'd3;
      run_vec("post_rst", 17'd12);
      check("post_rst_cnt", result_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
